// File: rtl/uart_pkg.sv
// Shared constants for the UART TX arbiter: state encoding and data width.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  localparam logic [1:0] ARB_IDLE      = 2'd0;
  localparam logic [1:0] ARB_START     = 2'd1;
  localparam logic [1:0] ARB_WAIT_DONE = 2'd2;
  localparam logic [1:0] ARB_GAP       = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ARB_IDLE,
    S_START = ARB_START,
    S_WAIT  = ARB_WAIT_DONE,
    S_GAP   = ARB_GAP
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester/transmitter bundle for uart_tx_arbiter; slave = arbiter side.
interface uart_tx_arb_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                i_reqValid;
  logic [UART_DATA_BITS*NUM_REQ-1:0] i_reqData;
  logic [NUM_REQ-1:0]                o_reqReady;
  logic                              o_txStart;
  logic [UART_DATA_BITS-1:0]         o_txByte;
  logic                              i_txDone;
  logic [IDX_W-1:0]                  o_grantIdx;
  logic                              o_busy;
  logic                              o_timeout;

  modport slave (
    input  i_reqValid, i_reqData, i_txDone,
    output o_reqReady, o_txStart, o_txByte, o_grantIdx, o_busy, o_timeout
  );

  modport master (
    output i_reqValid, i_reqData, i_txDone,
    input  o_reqReady, o_txStart, o_txByte, o_grantIdx, o_busy, o_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter_picker.sv
// Combinational round-robin search: first set request at or above ptr_i, wrapping.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int j;
      j = int'(ptr_i) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found_o && req_i[j]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(j);
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Optional watchdog in WAIT_DONE enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CLKS     = 0,
  parameter int TIMEOUT_CLKS = 4096
) (
  input  logic          i_clk,
  input  logic          i_rst,
  uart_tx_arb_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int GW    = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

  arb_state_e                state_q;
  logic [IDX_W-1:0]          ptr_q, ptr_d, grant_q, win;
  logic [NUM_REQ-1:0]        ready_q, ready_d;
  logic                      start_q, busy_q, timeout_q, found;
  logic [UART_DATA_BITS-1:0] byte_q, byte_d;
  logic [GW-1:0]             gap_cnt_q;
  logic                      to_hit, frame_end;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i   (bus.i_reqValid),
    .ptr_i   (ptr_q),
    .found_o (found),
    .idx_o   (win)
  );

  always_comb begin
    byte_d = '0;
    for (int n = 0; n < NUM_REQ; n++)
      if (win == IDX_W'(n)) byte_d = bus.i_reqData[n*UART_DATA_BITS +: UART_DATA_BITS];
    ready_d = NUM_REQ'(1) << win;
    ptr_d   = (win == IDX_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  logic [TW-1:0] to_cnt_q;

  assign to_hit = (to_cnt_q == TW'(TIMEOUT_CLKS-1));

  always_ff @(posedge i_clk) begin
    if (i_rst || state_q != S_WAIT) to_cnt_q <= '0;
    else                            to_cnt_q <= to_cnt_q + 1'b1;
  end
`else
  assign to_hit = 1'b0;
`endif

  assign frame_end = bus.i_txDone || to_hit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      ready_q   <= '0;
      start_q   <= 1'b0;
      byte_q    <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      gap_cnt_q <= '0;
    end else begin
      ready_q   <= '0;
      start_q   <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: if (found) begin
          byte_q  <= byte_d;
          grant_q <= win;
          ptr_q   <= ptr_d;
          ready_q <= ready_d;
          start_q <= 1'b1;
          busy_q  <= 1'b1;
          state_q <= S_START;
        end
        S_START: state_q <= S_WAIT;
        S_WAIT: if (frame_end) begin
          // txDone takes precedence; a late done on the timeout edge is not a timeout
          timeout_q <= !bus.i_txDone;
          if (GAP_CLKS > 0) begin
            gap_cnt_q <= '0;
            state_q   <= S_GAP;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GW'(GAP_CLKS-1)) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          gap_cnt_q <= gap_cnt_q + 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.o_reqReady = ready_q;
  assign bus.o_txStart  = start_q;
  assign bus.o_txByte   = byte_q;
  assign bus.o_grantIdx = grant_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_timeout  = timeout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: stimulus pushes expected grants, a negedge monitor checks each start.
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [9:0] sb_q[$];
  logic [9:0] sb_exp;

  uart_tx_arb_if #(.NUM_REQ(4)) busA ();
  uart_tx_arb_if #(.NUM_REQ(4)) busB ();

  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CLKS(0), .TIMEOUT_CLKS(16)) dutA (
    .i_clk (clk), .i_rst (rst), .bus (busA.slave));
  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CLKS(5), .TIMEOUT_CLKS(16)) dutB (
    .i_clk (clk), .i_rst (rst), .bus (busB.slave));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input logic [7:0] b);
    sb_q.push_back({2'(idx), b});
  endtask

  task automatic setA(input int n, input logic v, input logic [7:0] d);
    busA.i_reqValid[n]       = v;
    busA.i_reqData[n*8 +: 8] = d;
  endtask

  task automatic setB(input int n, input logic v, input logic [7:0] d);
    busB.i_reqValid[n]       = v;
    busB.i_reqData[n*8 +: 8] = d;
  endtask

  task automatic doneA();
    busA.i_txDone = 1'b1;
    tick();
    busA.i_txDone = 1'b0;
  endtask

  task automatic doneB();
    busB.i_txDone = 1'b1;
    tick();
    busB.i_txDone = 1'b0;
  endtask

  task automatic chk_zeroA(input string pfx);
    chk({pfx, "_busy"},    32'(busA.o_busy),     0);
    chk({pfx, "_start"},   32'(busA.o_txStart),  0);
    chk({pfx, "_byte"},    32'(busA.o_txByte),   0);
    chk({pfx, "_grant"},   32'(busA.o_grantIdx), 0);
    chk({pfx, "_ready"},   32'(busA.o_reqReady), 0);
    chk({pfx, "_timeout"}, 32'(busA.o_timeout),  0);
  endtask

  // Monitor: every start pulse on dutA must match the next queued grant.
  always @(negedge clk) begin
    if (!rst && busA.o_txStart) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_start grant=%0d byte=%0h required=none", busA.o_grantIdx, busA.o_txByte);
      end else begin
        sb_exp = sb_q.pop_front();
        chk("sb_grant", 32'(busA.o_grantIdx), 32'(sb_exp[9:8]));
        chk("sb_byte",  32'(busA.o_txByte),   32'(sb_exp[7:0]));
        chk("sb_ready", 32'(busA.o_reqReady), 32'(4'b0001 << sb_exp[9:8]));
      end
    end
  end

  initial begin
    busA.i_reqValid = '0; busA.i_reqData = '0; busA.i_txDone = 1'b0;
    busB.i_reqValid = '0; busB.i_reqData = '0; busB.i_txDone = 1'b0;

    // reset state
    tick(); tick();
    chk_zeroA("rst");
    chk("rst_busyB", 32'(busB.o_busy), 0);
    rst = 1'b0;
    tick();

    // single request, requester 2
    setA(2, 1'b1, 8'hA5); push(2, 8'hA5);
    tick();
    chk("t1_start", 32'(busA.o_txStart), 1);
    chk("t1_busy",  32'(busA.o_busy),    1);
    tick();
    setA(2, 1'b0, 8'h00);
    chk("t1_start_one_cycle", 32'(busA.o_txStart), 0);
    chk("t1_byte_hold", 32'(busA.o_txByte), 32'hA5);
    repeat (9) tick();
    doneA();
    chk("t1_busy_fall", 32'(busA.o_busy), 0);

    // simultaneous 0 and 1 from reset; done during START is ignored
    rst = 1'b1; tick(); rst = 1'b0;
    setA(0, 1'b1, 8'h11); setA(1, 1'b1, 8'h22);
    push(0, 8'h11); push(1, 8'h22);
    tick();
    chk("t2_start0", 32'(busA.o_txStart), 1);
    busA.i_txDone = 1'b1;
    tick();
    busA.i_txDone = 1'b0;
    setA(0, 1'b0, 8'h00);
    tick();
    chk("t2_done_in_start_ignored", 32'(busA.o_busy), 1);
    repeat (2) tick();
    doneA();
    chk("t2_idle_after_done", 32'(busA.o_busy), 0);
    tick();
    chk("t2_start1", 32'(busA.o_txStart), 1);
    chk("t2_grant1", 32'(busA.o_grantIdx), 1);
    setA(1, 1'b0, 8'h00);
    tick();
    doneA();
    tick();

    // round-robin, all four continuously valid
    rst = 1'b1; tick(); rst = 1'b0;
    for (int n = 0; n < 4; n++) setA(n, 1'b1, 8'(8'h30 + n));
    for (int f = 0; f < 8; f++) push(f % 4, 8'(8'h30 + f % 4));
    for (int f = 0; f < 8; f++) begin
      tick();
      chk("t3_start", 32'(busA.o_txStart), 1);
      tick();
      doneA();
    end
    busA.i_reqValid = '0;
    tick();

    // reset during WAIT_DONE, requester 3 pending
    setA(1, 1'b1, 8'h55); push(1, 8'h55);
    tick();
    tick();
    setA(1, 1'b0, 8'h00); setA(3, 1'b1, 8'h77);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk_zeroA("t4");
    push(3, 8'h77);
    tick();
    chk("t4_start3", 32'(busA.o_txStart), 1);
    chk("t4_grant3", 32'(busA.o_grantIdx), 3);
    tick();
    setA(3, 1'b0, 8'h00);
    doneA();
    tick();

    // no done from transmitter
    setA(0, 1'b1, 8'h99); push(0, 8'h99);
    tick();
    tick();
    setA(0, 1'b0, 8'h00);
`ifdef UART_TX_ARB_TIMEOUT_EN
    repeat (15) tick();
    chk("t5_no_early_timeout", 32'(busA.o_timeout), 0);
    chk("t5_busy_before", 32'(busA.o_busy), 1);
    tick();
    chk("t5_timeout", 32'(busA.o_timeout), 1);
    chk("t5_idle", 32'(busA.o_busy), 0);
    setA(1, 1'b1, 8'h5A); push(1, 8'h5A);
    tick();
    chk("t5_timeout_pulse", 32'(busA.o_timeout), 0);
    chk("t5_regrant", 32'(busA.o_txStart), 1);
    tick();
    setA(1, 1'b0, 8'h00);
    doneA();
    tick();
`else
    begin
      int to_seen;
      to_seen = 0;
      repeat (40) begin
        tick();
        if (busA.o_timeout) to_seen++;
      end
      chk("t5_busy_hold", 32'(busA.o_busy), 1);
      chk("t5_no_timeout", 32'(to_seen), 0);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    tick();
`endif

    // inter-frame gap of 5 on dutB
    setB(0, 1'b1, 8'h61); setB(1, 1'b1, 8'h62);
    tick();
    chk("t6_start0", 32'(busB.o_txStart), 1);
    chk("t6_grant0", 32'(busB.o_grantIdx), 0);
    chk("t6_byte0", 32'(busB.o_txByte), 32'h61);
    tick();
    setB(0, 1'b0, 8'h00);
    tick();
    doneB();
    chk("t6_busy_in_gap", 32'(busB.o_busy), 1);
    for (int k = 2; k <= 6; k++) begin
      tick();
      chk("t6_no_early_start", 32'(busB.o_txStart), 0);
    end
    tick();
    chk("t6_start1_at_d7", 32'(busB.o_txStart), 1);
    chk("t6_grant1", 32'(busB.o_grantIdx), 1);
    chk("t6_byte1", 32'(busB.o_txByte), 32'h62);
    tick();
    setB(1, 1'b0, 8'h00);
    doneB();
    repeat (4) tick();
    chk("t6_busy_late_gap", 32'(busB.o_busy), 1);
    repeat (2) tick();
    chk("t6_busy_fall", 32'(busB.o_busy), 0);

    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter among `NUM_REQ` byte producers. It sits between the requesters (command responders, status reporters, loopback echo) and the single UART TX serializer. It grants one requester at a time, captures that requester's byte and issues a one-cycle start to the transmitter. It then waits for the transmitter's completion pulse and enforces a configurable inter-frame gap before arbitrating again.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; legal range 2..16.
- `GAP_CLKS`, 0: idle clocks inserted after each frame completes.
- `TIMEOUT_CLKS`, 4096: watchdog limit in WAIT_DONE. Used only with `UART_TX_ARB_TIMEOUT_EN`.

Ports:
- `i_clk`, input, 1: single clock.
- `i_rst`, input, 1: reset, synchronous, active-high.
- `i_reqValid`, input, `NUM_REQ`: requester n holds bit n high while it has a byte pending.
- `i_reqData`, input, `8*NUM_REQ`: byte of requester n on bits `[8n+7:8n]`.
- `o_reqReady`, output, `NUM_REQ`: one-hot, one-cycle pulse that acknowledges capture of the granted byte.
- `o_txStart`, output, 1: one-cycle start pulse to the transmitter.
- `o_txByte`, output, 8: captured byte; stable from the start pulse until the return to IDLE.
- `i_txDone`, input, 1: transmitter completion pulse, one cycle.
- `o_grantIdx`, output, `$clog2(NUM_REQ)`: index of the current or most recent winner.
- `o_busy`, output, 1: high in every state except IDLE.
- `o_timeout`, output, 1: one-cycle watchdog pulse.

## Operation
- States:
  - IDLE.
  - START: `o_txStart` and `o_reqReady[w]` are high.
  - WAIT_DONE.
  - GAP.
- IDLE:
  - If `i_reqValid` is nonzero, select winner w, the first set bit searching upward from `r_ptr` with wrap-around.
  - On the same edge: capture `i_reqData[w]` into `o_txByte`, set `o_grantIdx <= w`, set `r_ptr <= (w+1) mod NUM_REQ`, and go to START.
  - If `i_reqValid` is zero, stay in IDLE; `r_ptr` is unchanged.
- START: lasts exactly one cycle, then go to WAIT_DONE.
- WAIT_DONE:
  - On `i_txDone`, go to GAP if `GAP_CLKS > 0`, otherwise to IDLE.
  - `i_txDone` is ignored in every other state, including START.
- GAP: count `GAP_CLKS` cycles, then go to IDLE. The counter clears on entry.
- Handshake rules for requesters:
  - A requester keeps valid and data stable until it sees its ready bit.
  - It may drop valid, or present its next byte, in the cycle after ready.
  - Valid changes of other requesters during a frame have no effect until IDLE.
- A requester that drops valid before being granted is never granted for that byte. There is no error.
- Reset, from any state including mid-frame:
  - State goes to IDLE and `r_ptr` to 0.
  - Every output resets to 0: `o_reqReady`, `o_txStart`, `o_txByte`, `o_grantIdx`, `o_busy`, `o_timeout`.
  - The transmitter shares `i_rst`, so no abort handshake is needed.

## Timing
- Request latency: `i_reqValid` sampled high in IDLE at cycle N gives `o_txStart` and `o_reqReady[w]` high in cycle N+1.
- Turnaround: `i_txDone` at cycle D means IDLE is reached at D+1+`GAP_CLKS`. The earliest next `o_txStart` is at D+2+`GAP_CLKS`.
- Start pulse: `o_txStart` is never high in consecutive cycles. It is never high while `o_busy` was high in the previous cycle, except on the IDLE→START transition.
- Fairness: under continuous requests from all requesters, no requester waits more than `NUM_REQ-1` frames.
- `o_busy` is registered; it rises with the START cycle and falls on the IDLE entry edge.

## Configuration
- `UART_TX_ARB_TIMEOUT_EN` defined:
  - A counter runs in WAIT_DONE, cleared on entry.
  - If it reaches `TIMEOUT_CLKS` without `i_txDone`, pulse `o_timeout` for one cycle and go to GAP, or to IDLE if `GAP_CLKS` is 0.
  - Arbitration continues normally afterwards.
- `UART_TX_ARB_TIMEOUT_EN` not defined:
  - No counter is built; `o_timeout` is tied to 0.
  - WAIT_DONE waits indefinitely.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding localparams `ARB_IDLE`, `ARB_START`, `ARB_WAIT_DONE`, `ARB_GAP` (2-bit);
  - the data width constant `UART_DATA_BITS = 8`.
- One sub-module, `rr_priority_picker`:
  - purely combinational;
  - inputs: request vector and `r_ptr`;
  - outputs: `found` and winner index.
- The top level holds the FSM, the counters and the capture registers.

## Test plan
- Single request: `NUM_REQ=4`, `GAP_CLKS=0`, requester 2 asserts valid with 0xA5 → next cycle `o_txStart=1`, `o_reqReady=4'b0100`, `o_txByte=0xA5`, `o_grantIdx=2`. Drive `i_txDone` 10 cycles later → `o_busy` low one cycle after.
- Simultaneous requests: requesters 0 and 1 valid together, with 0x11 and 0x22, from reset → 0x11 sent first. 0x22 is granted on the first IDLE cycle after done.
- Round-robin: all four requesters continuously valid for 8 frames → grant order 0,1,2,3,0,1,2,3.
- Gap: `GAP_CLKS=5`, two back-to-back requests, done at cycle D → second `o_txStart` at D+7, never earlier.
- Reset mid-frame: assert `i_rst` for 1 cycle during WAIT_DONE → all outputs 0 next cycle. A pending requester 3 is then granted first, because the pointer is 0 and requesters 0–2 are idle.
- Timeout, with `UART_TX_ARB_TIMEOUT_EN` and `TIMEOUT_CLKS=16`: never pulse `i_txDone` → `o_timeout` pulses once 16 cycles after entering WAIT_DONE and the next request is granted. With the macro undefined, `o_busy` stays high indefinitely.
